// File: rtl/bus_debug_unit_if.sv
// Shared-bus view of the debug unit: drive request/mode in, bus sample in, drive value and enable out.
// Latency: pure wiring, no storage.
// Backpressure: none; the bus is sampled and driven every cycle.
interface bus_debug_unit_if #(
    parameter int WIDTH = 16
);
    logic             drive_req;
    logic [1:0]       drive_mode;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] bus_out;
    logic             bus_oe;

    modport master (
        input  drive_req,
        input  drive_mode,
        input  bus_in,
        output bus_out,
        output bus_oe
    );

    modport slave (
        output drive_req,
        output drive_mode,
        output bus_in,
        input  bus_out,
        input  bus_oe
    );
endinterface

// File: rtl/bus_debug_unit.sv
// Bus debug unit: drives a stepped test pattern onto the shared bus and captures triggered bus samples.
// Latency: drive/capture state updates 1 clk after a step; rd_data 1 clk after rd_idx; bus_oe combinational.
// Backpressure: none; every step is consumed, capture halts when full unless the buffer wraps.
module bus_debug_unit #(
    parameter int               WIDTH = 16,
    parameter int               DEPTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 'h5500,
    parameter bit               WRAP  = 1'b0,
    parameter int               LED_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     step,
    bus_debug_unit_if.master         bus,
    input  logic                     arm,
    input  logic                     stop,
    input  logic [WIDTH-1:0]         trig_value,
    input  logic [WIDTH-1:0]         trig_mask,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   cap_count,
    output logic                     full,
    output logic [1:0]               state,
    output logic [LED_W-1:0]         led
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ARMED     = 2'b01,
        ST_CAPTURING = 2'b10,
        ST_DONE      = 2'b11
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] drive_reg;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cap_cnt;
    logic [AW-1:0]    oldest;
    logic [AW-1:0]    rd_ptr;
    logic             match;
    logic             do_cap;
    logic             do_clear;
    logic [WIDTH-1:0] mem [DEPTH];

    assign bus.bus_out = drive_reg;
    assign bus.bus_oe  = bus.drive_req;
    assign state       = state_q;
    assign cap_count   = cap_cnt;
    assign full        = (cap_cnt == CW'(DEPTH));
    assign match       = (((bus.bus_in ^ trig_value) & trig_mask) == '0);

    // Only a wrapped, full buffer has its oldest entry anywhere but slot 0.
    assign oldest = (WRAP && full) ? wr_ptr : '0;
    assign rd_ptr = oldest + rd_idx;

    // Test-pattern generator: advances on each step while the bus is requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            drive_reg <= SEED;
        end else if (step && bus.drive_req) begin
            case (bus.drive_mode)
                2'b00:   drive_reg <= drive_reg + WIDTH'(1);
                2'b01:   drive_reg <= drive_reg - WIDTH'(1);
                2'b10:   drive_reg <= drive_reg;
                default: drive_reg <= {drive_reg[WIDTH-2:0], drive_reg[WIDTH-1]};
            endcase
        end
    end

    // Trigger/capture sequencing; stop overrides arm and capture in every state.
    always_comb begin
        state_d  = state_q;
        do_cap   = 1'b0;
        do_clear = 1'b0;
        if (step) begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (!stop && arm) begin
                        state_d  = ST_ARMED;
                        do_clear = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (stop) begin
                        state_d = ST_DONE;
                    end else if (match) begin
                        do_cap  = 1'b1;
                        state_d = ST_CAPTURING;
                    end
                end
                ST_CAPTURING: begin
                    if (stop) begin
                        state_d = ST_DONE;
                    end else begin
                        do_cap = 1'b1;
                        // The capture that fills a non-wrapping buffer also ends the run.
                        if (!WRAP && (cap_cnt == CW'(DEPTH - 1))) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, write pointer, fill count and LED snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wr_ptr  <= '0;
            cap_cnt <= '0;
            led     <= '0;
        end else begin
            state_q <= state_d;
            if (do_clear) begin
                wr_ptr  <= '0;
                cap_cnt <= '0;
            end else if (do_cap) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (!full) begin
                    cap_cnt <= cap_cnt + CW'(1);
                end
                led <= bus.bus_in[LED_W-1:0];
            end
        end
    end

    // Capture storage; contents are left alone by reset.
    always_ff @(posedge clk) begin
        if (!reset && do_cap) begin
            mem[wr_ptr] <= bus.bus_in;
        end
    end

    // Registered readback, refreshed every clock regardless of step.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_ptr];
        end
    end
endmodule

// File: tb/tb_bus_debug_unit.sv
// Bench for bus_debug_unit: a non-wrapping self-driven unit, a wrapping unit fed by the bench, and a rotate-seeded unit.
// Expected values come from a queue-based model of the capture history plus directed constants.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_bus_debug_unit;
    localparam int W = 16;
    localparam int D = 8;
    localparam int S_IDLE = 0, S_ARMED = 1, S_CAP = 2, S_DONE = 3;

    logic        clk = 1'b0;
    logic        reset, step, arm, stop;
    logic [15:0] trig_value, trig_mask, bus_in1;
    logic [2:0]  rd_idx;
    logic        drv_req [3];
    logic [1:0]  drv_mode [3];

    logic [15:0] o_rd [3];
    logic [3:0]  o_cnt [3];
    logic        o_full [3];
    logic [1:0]  o_state [3];
    logic [4:0]  o_led [3];
    logic [15:0] o_bus [3];
    logic        o_oe [3];

    bus_debug_unit_if #(.WIDTH(W)) if0 ();
    bus_debug_unit_if #(.WIDTH(W)) if1 ();
    bus_debug_unit_if #(.WIDTH(W)) if2 ();

    assign if0.drive_req  = drv_req[0];
    assign if1.drive_req  = drv_req[1];
    assign if2.drive_req  = drv_req[2];
    assign if0.drive_mode = drv_mode[0];
    assign if1.drive_mode = drv_mode[1];
    assign if2.drive_mode = drv_mode[2];
    assign if0.bus_in     = if0.bus_out;
    assign if1.bus_in     = bus_in1;
    assign if2.bus_in     = if2.bus_out;
    assign o_bus[0] = if0.bus_out;
    assign o_bus[1] = if1.bus_out;
    assign o_bus[2] = if2.bus_out;
    assign o_oe[0]  = if0.bus_oe;
    assign o_oe[1]  = if1.bus_oe;
    assign o_oe[2]  = if2.bus_oe;

    bus_debug_unit #(.WIDTH(W), .DEPTH(D), .SEED(16'h5500), .WRAP(1'b0), .LED_W(5)) u0 (
        .clk(clk), .reset(reset), .step(step), .bus(if0), .arm(arm), .stop(stop),
        .trig_value(trig_value), .trig_mask(trig_mask), .rd_idx(rd_idx), .rd_data(o_rd[0]),
        .cap_count(o_cnt[0]), .full(o_full[0]), .state(o_state[0]), .led(o_led[0]));

    bus_debug_unit #(.WIDTH(W), .DEPTH(D), .SEED(16'h5500), .WRAP(1'b1), .LED_W(5)) u1 (
        .clk(clk), .reset(reset), .step(step), .bus(if1), .arm(arm), .stop(stop),
        .trig_value(trig_value), .trig_mask(trig_mask), .rd_idx(rd_idx), .rd_data(o_rd[1]),
        .cap_count(o_cnt[1]), .full(o_full[1]), .state(o_state[1]), .led(o_led[1]));

    bus_debug_unit #(.WIDTH(W), .DEPTH(D), .SEED(16'h8001), .WRAP(1'b0), .LED_W(5)) u2 (
        .clk(clk), .reset(reset), .step(step), .bus(if2), .arm(arm), .stop(stop),
        .trig_value(trig_value), .trig_mask(trig_mask), .rd_idx(rd_idx), .rd_data(o_rd[2]),
        .cap_count(o_cnt[2]), .full(o_full[2]), .state(o_state[2]), .led(o_led[2]));

    always #5 clk = ~clk;

    // Reference model: capture history as queues, oldest at the front.
    logic [15:0] m_drv [3];
    int          m_st [3];
    logic [4:0]  m_led [3];
    logic [15:0] m_rd [3];
    bit          m_rdv [3];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            logic [15:0] q [$];
            logic [15:0] b;
            bit          hit;
            bit          wrap;
            if (i == 0) q = q0; else if (i == 1) q = q1; else q = q2;
            b    = (i == 1) ? bus_in1 : m_drv[i];
            wrap = (i == 1);
            if (reset) begin
                m_drv[i] = (i == 2) ? 16'h8001 : 16'h5500;
                m_st[i]  = S_IDLE;
                q.delete();
                m_led[i] = '0;
                m_rd[i]  = '0;
                m_rdv[i] = 1'b1;
            end else begin
                m_rdv[i] = (int'(rd_idx) < q.size());
                if (m_rdv[i]) m_rd[i] = q[rd_idx];
                if (step) begin
                    if (drv_req[i]) begin
                        case (drv_mode[i])
                            2'd0:    m_drv[i] = m_drv[i] + 16'd1;
                            2'd1:    m_drv[i] = m_drv[i] - 16'd1;
                            2'd2:    m_drv[i] = m_drv[i];
                            default: m_drv[i] = {m_drv[i][14:0], m_drv[i][15]};
                        endcase
                    end
                    hit = (((b ^ trig_value) & trig_mask) == 16'h0);
                    case (m_st[i])
                        S_IDLE, S_DONE: begin
                            if (arm && !stop) begin
                                m_st[i] = S_ARMED;
                                q.delete();
                            end
                        end
                        S_ARMED: begin
                            if (stop) m_st[i] = S_DONE;
                            else if (hit) begin
                                q.push_back(b);
                                m_led[i] = b[4:0];
                                m_st[i]  = S_CAP;
                            end
                        end
                        default: begin
                            if (stop) m_st[i] = S_DONE;
                            else begin
                                q.push_back(b);
                                if (q.size() > D) void'(q.pop_front());
                                m_led[i] = b[4:0];
                                if (!wrap && q.size() == D) m_st[i] = S_DONE;
                            end
                        end
                    endcase
                end
            end
            if (i == 0) q0 = q; else if (i == 1) q1 = q; else q2 = q;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            int n;
            n = (i == 0) ? q0.size() : ((i == 1) ? q1.size() : q2.size());
            chk($sformatf("u%0d.bus_out", i), 32'(o_bus[i]), 32'(m_drv[i]));
            chk($sformatf("u%0d.bus_oe", i), 32'(o_oe[i]), 32'(drv_req[i]));
            chk($sformatf("u%0d.state", i), 32'(o_state[i]), 32'(m_st[i]));
            chk($sformatf("u%0d.cap_count", i), 32'(o_cnt[i]), 32'(n));
            chk($sformatf("u%0d.full", i), 32'(o_full[i]), 32'(n == D));
            chk($sformatf("u%0d.led", i), 32'(o_led[i]), 32'(m_led[i]));
            if (m_rdv[i]) chk($sformatf("u%0d.rd_data", i), 32'(o_rd[i]), 32'(m_rd[i]));
        end
    endtask

    task automatic clk_cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic cycles(input int n);
        repeat (n) clk_cycle();
    endtask

    task automatic steps(input int n);
        step = 1'b1;
        repeat (n) clk_cycle();
        step = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; step = 1'b0; arm = 1'b0; stop = 1'b0;
        trig_value = '0; trig_mask = 16'hFFFF; rd_idx = '0; bus_in1 = '0;
        for (int i = 0; i < 3; i++) begin
            drv_req[i]  = 1'b0;
            drv_mode[i] = 2'd0;
        end
        cycles(2);
        chk("reset.bus_out", 32'(o_bus[0]), 32'h5500);
        chk("reset.rd_data", 32'(o_rd[1]), 32'h0);
        reset = 1'b0;

        // Drive pattern: increment, decrement, rotate.
        drv_req[0] = 1'b1; drv_req[1] = 1'b1;
        steps(3);
        chk("inc3.bus_out", 32'(o_bus[0]), 32'h5503);
        chk("inc3.bus_oe", 32'(o_oe[0]), 32'h1);
        drv_mode[0] = 2'd1; drv_mode[1] = 2'd1;
        steps(1);
        chk("dec.bus_out", 32'(o_bus[0]), 32'h5502);
        drv_req[0] = 1'b0; drv_req[1] = 1'b0;
        drv_req[2] = 1'b1; drv_mode[2] = 2'd3;
        steps(1);
        chk("rotl.bus_out", 32'(o_bus[2]), 32'h0003);
        drv_req[2] = 1'b0;

        // Non-wrapping capture of the self-driven count from 5502.
        do_reset();
        trig_value = 16'h5502; trig_mask = 16'hFFFF;
        arm = 1'b1; steps(1); arm = 1'b0;
        drv_req[0] = 1'b1; drv_mode[0] = 2'd0;
        steps(2);
        chk("pretrig.state", 32'(o_state[0]), S_ARMED);
        chk("pretrig.cnt", 32'(o_cnt[0]), 32'h0);
        steps(8);
        chk("fill.state", 32'(o_state[0]), S_DONE);
        chk("fill.full", 32'(o_full[0]), 32'h1);
        chk("fill.led", 32'(o_led[0]), 32'h09);
        drv_req[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rd_idx = 3'(k);
            cycles(1);
            chk($sformatf("nowrap.rd%0d", k), 32'(o_rd[0]), 32'h5502 + 32'(k));
        end

        // Wrapping capture of 0..10 with an always-matching trigger.
        do_reset();
        trig_mask = 16'h0;
        arm = 1'b1; steps(1); arm = 1'b0;
        for (int v = 0; v <= 10; v++) begin
            bus_in1 = 16'(v);
            steps(1);
        end
        chk("wrap.full", 32'(o_full[1]), 32'h1);
        chk("wrap.state", 32'(o_state[1]), S_CAP);
        rd_idx = 3'd0; cycles(1);
        chk("wrap.rd0", 32'(o_rd[1]), 32'd3);
        rd_idx = 3'd7; cycles(1);
        chk("wrap.rd7", 32'(o_rd[1]), 32'd10);
        stop = 1'b1; steps(1); stop = 1'b0;
        chk("wrap.stop", 32'(o_state[1]), S_DONE);
        bus_in1 = 16'h00FF;
        steps(2);
        chk("wrap.after.state", 32'(o_state[1]), S_DONE);
        chk("wrap.after.led", 32'(o_led[1]), 32'd10);

        // Stop beats arm while ARMED; arm from DONE re-arms.
        do_reset();
        trig_value = 16'h1234; trig_mask = 16'hFFFF; bus_in1 = 16'h0;
        arm = 1'b1; steps(1);
        stop = 1'b1; steps(1); stop = 1'b0;
        chk("stoparm.state", 32'(o_state[1]), S_DONE);
        chk("stoparm.cnt", 32'(o_cnt[1]), 32'h0);
        steps(1); arm = 1'b0;
        chk("rearm.state", 32'(o_state[1]), S_ARMED);

        // Reset in the middle of a capture run, together with a step.
        trig_mask = 16'h0; drv_req[0] = 1'b1;
        for (int v = 0; v < 5; v++) begin
            bus_in1 = 16'h00A0 + 16'(v);
            steps(1);
        end
        chk("mid.cnt", 32'(o_cnt[1]), 32'd5);
        chk("mid.state", 32'(o_state[1]), S_CAP);
        reset = 1'b1; step = 1'b1;
        cycles(1);
        reset = 1'b0; step = 1'b0;
        chk("midrst.state", 32'(o_state[1]), S_IDLE);
        chk("midrst.cnt", 32'(o_cnt[1]), 32'h0);
        chk("midrst.bus_out", 32'(o_bus[0]), 32'h5500);
        chk("midrst.led", 32'(o_led[1]), 32'h0);
        drv_req[0] = 1'b0;

        // No step: inputs toggle, nothing but bus_oe may move.
        arm = 1'b1; steps(1); arm = 1'b0;
        for (int v = 0; v < 5; v++) begin
            bus_in1 = 16'h00B0 + 16'(v);
            steps(1);
        end
        for (int c = 0; c < 20; c++) begin
            arm = 1'($urandom); stop = 1'($urandom);
            for (int i = 0; i < 3; i++) begin
                drv_req[i]  = 1'($urandom);
                drv_mode[i] = 2'($urandom);
            end
            bus_in1 = 16'($urandom); trig_value = 16'($urandom);
            trig_mask = 16'($urandom); rd_idx = 3'($urandom);
            cycles(1);
        end
        arm = 1'b0; stop = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rd_idx = 3'(k);
            cycles(1);
            chk($sformatf("hold.rd%0d", k), 32'(o_rd[1]), 32'h00B0 + 32'(k));
        end

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) begin
                case ($urandom_range(0, 3))
                    0: trig_mask = 16'h0;
                    1: trig_mask = 16'h000F;
                    2: trig_mask = 16'h0003;
                    default: trig_mask = 16'($urandom);
                endcase
                trig_value = 16'($urandom);
            end
            reset = ($urandom_range(0, 99) == 0);
            step  = 1'($urandom);
            arm   = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < 3; i++) begin
                drv_req[i]  = 1'($urandom);
                drv_mode[i] = 2'($urandom);
            end
            bus_in1 = 16'($urandom);
            rd_idx  = 3'($urandom);
            clk_cycle();
        end
        reset = 1'b0; step = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
